mips_multicycle_control: RTL and testbench

//  Multicycle main control FSM for the MIPS datapath. Sequences each instruction through

---
 rtl/mips_multicycle_control_if.sv | 39 +++
 rtl/mips_multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS main controller.
// Latency: none (wires only).
// Backpressure: mem_ready from memory stalls the controller; nothing else pushes back.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       ula_src_a;
  logic [1:0] ula_src_b;
  logic [1:0] ula_operation;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       trap;
  logic [3:0] state;

  // controller side
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b, ula_operation,
           pc_source, instr_done, trap, state
  );

  // datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b, ula_operation,
           pc_source, instr_done, trap, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/writeback, drives datapath selects.
// Latency: R/addi/sw 4, lw 5, beq/j 3 cycles FETCH-to-FETCH; outputs decoded combinationally from state.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold with strobes stable until mem_ready (when MEM_WAIT_EN=1).
module mips_multicycle_control #(
  parameter bit MEM_WAIT_EN     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  mips_multicycle_control_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
  } ctl_t;

  state_t state_q, state_d;
  logic   out_en;   // low from reset assertion until the first edge after release
  logic   rdy;
  ctl_t   ctl;

  assign rdy = MEM_WAIT_EN ? ctrl.mem_ready : 1'b1;

  // State register; reset aborts any instruction and returns to FETCH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Output enable: keeps every strobe low in reset and for the release cycle, so
  // FETCH outputs (and FSM progress) begin one cycle after reset is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  // Next-state logic; frozen until outputs are enabled, unused codes recover to FETCH.
  always_comb begin
    state_d = state_q;
    if (out_en) begin
      case (state_q)
        S_FETCH:     if (rdy) state_d = S_DECODE;
        S_DECODE: begin
          case (ctrl.opcode)
            OP_RTYPE:      state_d = S_R_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            OP_ADDI:       state_d = S_ADDI_EXEC;
            default:       state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          endcase
        end
        // only lw/sw reach here and the IR holds the opcode steady
        S_MEM_ADDR:  state_d = (ctrl.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (rdy) state_d = S_MEM_WB;
        S_MEM_WRITE: if (rdy) state_d = S_FETCH;
        S_R_EXEC:    state_d = S_R_WB;
        S_ADDI_EXEC: state_d = S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_TRAP:      state_d = S_TRAP;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  // Output decode from state; everything defaults low and stays low while disabled.
  always_comb begin
    ctl = '0;
    if (out_en) begin
      case (state_q)
        S_FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.ula_src_b = 2'b01;
          ctl.pc_write  = rdy;
          ctl.ir_write  = rdy;
        end
        S_DECODE:    ctl.ula_src_b = 2'b11;
        S_MEM_ADDR, S_ADDI_EXEC: begin
          ctl.ula_src_a = 1'b1;
          ctl.ula_src_b = 2'b10;
        end
        S_MEM_READ: begin
          ctl.mem_read = 1'b1;
          ctl.i_or_d   = 1'b1;
        end
        S_MEM_WRITE: begin
          ctl.mem_write  = 1'b1;
          ctl.i_or_d     = 1'b1;
          ctl.instr_done = rdy;
        end
        S_MEM_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
          ctl.instr_done = 1'b1;
        end
        S_R_EXEC: begin
          ctl.ula_src_a     = 1'b1;
          ctl.ula_operation = 2'b10;
        end
        S_R_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = 1'b1;
          ctl.instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctl.ula_src_a     = 1'b1;
          ctl.ula_operation = 2'b01;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = 2'b01;
          ctl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctl.pc_write   = 1'b1;
          ctl.pc_source  = 2'b10;
          ctl.instr_done = 1'b1;
        end
        S_TRAP:  ctl.trap = 1'b1;
        default: ctl = '0;
      endcase
    end
  end

  assign ctrl.pc_write      = ctl.pc_write;
  assign ctrl.pc_write_cond = ctl.pc_write_cond;
  assign ctrl.i_or_d        = ctl.i_or_d;
  assign ctrl.mem_read      = ctl.mem_read;
  assign ctrl.mem_write     = ctl.mem_write;
  assign ctrl.ir_write      = ctl.ir_write;
  assign ctrl.mem_to_reg    = ctl.mem_to_reg;
  assign ctrl.reg_dst       = ctl.reg_dst;
  assign ctrl.reg_write     = ctl.reg_write;
  assign ctrl.ula_src_a     = ctl.ula_src_a;
  assign ctrl.ula_src_b     = ctl.ula_src_b;
  assign ctrl.ula_operation = ctl.ula_operation;
  assign ctrl.pc_source     = ctl.pc_source;
  assign ctrl.instr_done    = ctl.instr_done;
  assign ctrl.trap          = ctl.trap;
  assign ctrl.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed scenarios plus randomized instruction streams.
// Expected traces are built per instruction class from state sequences and stall counts.
// Second instance (no mem wait, no trap) checks the parameter variants.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       mem_ready2 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();
  mips_multicycle_control_if bus2 ();

  assign bus.opcode     = opcode;
  assign bus.mem_ready  = mem_ready;
  assign bus2.opcode    = opcode;
  assign bus2.mem_ready = mem_ready2;

  mips_multicycle_control dut (.clock(clk), .reset(rst_n), .ctrl(bus.master));
  mips_multicycle_control #(.MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0))
    dut2 (.clock(clk), .reset(rst_n), .ctrl(bus2.master));

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
  } ov_t;

  typedef struct {
    int       st;
    bit       rdy;
    bit [5:0] op;
  } step_t;

  step_t exp_q[$];
  int    instr_cnt;

  // Output table as listed per state.
  function automatic ov_t exp_vec(input int st, input bit rdy);
    ov_t o = '0;
    case (st)
      0:  begin o.mem_read = 1; o.ula_src_b = 2'b01; o.pc_write = rdy; o.ir_write = rdy; end
      1:  o.ula_src_b = 2'b11;
      2, 10: begin o.ula_src_a = 1; o.ula_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
      6:  begin o.ula_src_a = 1; o.ula_operation = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
      8:  begin o.ula_src_a = 1; o.ula_operation = 2'b01; o.pc_write_cond = 1;
                o.pc_source = 2'b01; o.instr_done = 1; end
      9:  begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      11: begin o.reg_write = 1; o.instr_done = 1; end
      12: o.trap = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic ov_t obs1();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.ula_src_a,
            bus.ula_src_b, bus.ula_operation, bus.pc_source, bus.instr_done, bus.trap};
  endfunction

  function automatic ov_t obs2();
    return {bus2.pc_write, bus2.pc_write_cond, bus2.i_or_d, bus2.mem_read, bus2.mem_write,
            bus2.ir_write, bus2.mem_to_reg, bus2.reg_dst, bus2.reg_write, bus2.ula_src_a,
            bus2.ula_src_b, bus2.ula_operation, bus2.pc_source, bus2.instr_done, bus2.trap};
  endfunction

  function automatic bit is_legal(input bit [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
  endfunction

  function automatic void push(input int st, input bit rdy, input bit [5:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.op = op;
    exp_q.push_back(s);
  endfunction

  // Expected trace of one instruction: fstall wait cycles in FETCH, mstall in the memory state.
  function automatic void add_instr(input bit [5:0] op, input int fstall, input int mstall,
                                    input int trap_len);
    for (int i = 0; i < fstall; i++) push(0, 1'b0, op);
    push(0, 1'b1, op);
    push(1, 1'($urandom), op);
    case (op)
      6'h00: begin push(6, 1'($urandom), op); push(7, 1'($urandom), op); end
      6'h23: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mstall; i++) push(3, 1'b0, op);
        push(3, 1'b1, op);
        push(4, 1'($urandom), op);
      end
      6'h2B: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mstall; i++) push(5, 1'b0, op);
        push(5, 1'b1, op);
      end
      6'h04: push(8, 1'($urandom), op);
      6'h02: push(9, 1'($urandom), op);
      6'h08: begin push(10, 1'($urandom), op); push(11, 1'($urandom), op); end
      default: for (int i = 0; i < trap_len; i++) push(12, 1'($urandom), op);
    endcase
    if (is_legal(op)) instr_cnt++;
  endfunction

  // Play the expected queue cycle by cycle, checking state, outputs and instr_done count.
  task automatic run_trace(input string tag);
    step_t e;
    ov_t   want;
    int    done_seen = 0;
    int    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      opcode    = e.op;
      mem_ready = e.rdy;
      #1;
      want = exp_vec(e.st, e.rdy);
      total++;
      if (bus.state !== 4'(e.st)) begin
        bad++;
        $display("FAIL %s cyc%0d state got %0d want %0d", tag, cyc, bus.state, e.st);
      end
      total++;
      if (obs1() !== want) begin
        bad++;
        $display("FAIL %s cyc%0d outputs got %h want %h (state %0d)", tag, cyc, obs1(), want, e.st);
      end
      if (bus.instr_done === 1'b1) done_seen++;
      cyc++;
    end
    total++;
    if (done_seen != instr_cnt) begin
      bad++;
      $display("FAIL %s instr_done count got %0d want %0d", tag, done_seen, instr_cnt);
    end
    instr_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (obs1() !== '0 || bus.state !== 4'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d outputs got %h state %0d want 0", i, obs1(), bus.state);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (obs1() !== '0) begin
      bad++;
      $display("FAIL reset_release outputs got %h want 0", obs1());
    end
    @(negedge clk); #1;
    total++;
    if (bus.state !== 4'd0 || obs1() !== exp_vec(0, 1'b1) || bus.mem_read !== 1'b1 || bus.pc_write !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_fetch state %0d outputs got %h want %h", bus.state, obs1(), exp_vec(0, 1'b1));
    end
    total++;
    if (bus2.state !== 4'd0) begin
      bad++;
      $display("FAIL reset_dut2 state got %0d want 0", bus2.state);
    end
    do_reset();
  endtask

  task automatic test_directed();
    add_instr(6'h00, 0, 0, 0);
    run_trace("rtype");
    add_instr(6'h23, 0, 2, 0);
    run_trace("lw_stall");
    add_instr(6'h2B, 0, 0, 0);
    run_trace("sw");
    add_instr(6'h04, 0, 0, 0);
    add_instr(6'h02, 0, 0, 0);
    run_trace("beq_j");
    add_instr(6'h08, 1, 0, 0);
    add_instr(6'h2B, 2, 3, 0);
    run_trace("addi_sw_stall");
  endtask

  task automatic test_back_to_back();
    bit [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    for (int i = 0; i < 60; i++)
      add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), 0);
    run_trace("random_stream");
  endtask

  task automatic test_mid_reset();
    add_instr(6'h2B, 0, 0, 0);
    void'(exp_q.pop_back());
    push(5, 1'b0, 6'h2B);
    instr_cnt = 0;
    run_trace("sw_before_abort");
    @(posedge clk); #2;
    total++;
    if (bus.mem_write !== 1'b1 || bus.state !== 4'd5) begin
      bad++;
      $display("FAIL stall_hold mem_write got %b state %0d want 1 state 5", bus.mem_write, bus.state);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs1() !== '0 || bus.state !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset outputs got %h state %0d want 0", obs1(), bus.state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    add_instr(6'h00, 0, 0, 0);
    run_trace("after_abort");
  endtask

  task automatic test_trap();
    bit [5:0] op;
    add_instr(6'h3F, 0, 0, 10);
    run_trace("trap_3f");
    do_reset();
    do op = 6'($urandom); while (is_legal(op));
    add_instr(op, 1, 0, 6);
    run_trace("trap_random");
    do_reset();
  endtask

  // Instance without memory wait or trap: mem_ready held low must not stall.
  task automatic test_params();
    int st_lw [6] = '{0, 1, 2, 3, 4, 0};
    int st_il [3] = '{0, 1, 0};
    mem_ready  = 1'b1;
    mem_ready2 = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      opcode = 6'h23; #1;
      total++;
      if (bus2.state !== 4'(st_lw[i]) || obs2() !== exp_vec(st_lw[i], 1'b1)) begin
        bad++;
        $display("FAIL nowait_lw cyc%0d state %0d outputs %h want state %0d outputs %h",
                 i, bus2.state, obs2(), st_lw[i], exp_vec(st_lw[i], 1'b1));
      end
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      opcode = 6'h3F; #1;
      total++;
      if (bus2.state !== 4'(st_il[i]) || obs2() !== exp_vec(st_il[i], 1'b1)) begin
        bad++;
        $display("FAIL notrap_illegal cyc%0d state %0d outputs %h want state %0d",
                 i, bus2.state, obs2(), st_il[i]);
      end
    end
  endtask

  initial begin
    instr_cnt = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_trap();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
